// File: rtl/serializador.sv
// Byte-to-serial transmitter: MSB-first, one bit per clock, back-to-back bytes,
// with a one-deep holding buffer so an upstream producer can stream at full rate.
module serializador #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC,
    parameter logic       IDLE_DK   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] in_data,
    input  logic       in_DK,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data,
    output logic       DK,
    output logic       frame
);

    localparam logic [2:0] LAST_BIT = 3'd7;

    logic [2:0] cnt_reg,   cnt_next;
    logic [7:0] sreg_reg,  sreg_next;
    logic       sdk_reg,   sdk_next;
    logic [7:0] hbuf_reg,  hbuf_next;
    logic       hdk_reg,   hdk_next;
    logic       hfull_reg, hfull_next;

    logic       at_last;
    logic       xfer;

    assign at_last  = (cnt_reg == LAST_BIT);
    // Ready only depends on registered state, so the handshake never loops back.
    assign in_ready = !hfull_reg || at_last;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_reg   <= 3'd0;
            sreg_reg  <= IDLE_CHAR;
            sdk_reg   <= IDLE_DK;
            hbuf_reg  <= 8'h00;
            hdk_reg   <= 1'b0;
            hfull_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            sreg_reg  <= sreg_next;
            sdk_reg   <= sdk_next;
            hbuf_reg  <= hbuf_next;
            hdk_reg   <= hdk_next;
            hfull_reg <= hfull_next;
        end
    end

    always_comb begin
        cnt_next   = cnt_reg + 3'd1;
        sreg_next  = sreg_reg;
        sdk_next   = sdk_reg;
        hbuf_next  = hbuf_reg;
        hdk_next   = hdk_reg;
        hfull_next = hfull_reg;

        if (at_last) begin
            // Byte boundary: buffered byte first, then a direct transfer, else idle fill.
            if (hfull_reg) begin
                sreg_next = hbuf_reg;
                sdk_next  = hdk_reg;
                if (xfer) begin
                    hbuf_next = in_data;
                    hdk_next  = in_DK;
                end else begin
                    hfull_next = 1'b0;
                end
            end else if (xfer) begin
                sreg_next = in_data;
                sdk_next  = in_DK;
            end else begin
                sreg_next = IDLE_CHAR;
                sdk_next  = IDLE_DK;
            end
        end else if (xfer) begin
            hbuf_next  = in_data;
            hdk_next   = in_DK;
            hfull_next = 1'b1;
        end
    end

    assign data  = sreg_reg[LAST_BIT - cnt_reg];
    assign DK    = sdk_reg;
    assign frame = (cnt_reg == 3'd0);

endmodule
